matrix_scan_ctrl: RTL and testbench
===================================

# matrix_scan_ctrl

Parametrised column-multiplexed LED matrix scanner. It drives a COLS x ROWS matrix one column at a time from one of PAGES frame buffers supplied by game logic, for example the board preview page and the hit-marker page. It adds per-column dwell, inter-column blanking against ghosting, tear-free frame latching and a blink mode. It sits between the game FSM and the matrix pins.

## Interface
- COLS, default 5: number of columns, ≥2.
- ROWS, default 7: number of rows, ≥1.
- PAGES, default 2: number of selectable frame pages, ≥2.
- DWELL, default 1: cycles each column is driven, ≥1.
- BLANK, default 0: all-off cycles inserted before each column, ≥0.
- BLINK_FRAMES, default 64: frames per blink half-period, ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; low forces idle and blank outputs.
- page_sel  in  $clog2(PAGES)  page to display.
- frame_data  in  PAGES*COLS*ROWS  all pages; column c of page p is frame_data[(p*COLS+c)*ROWS +: ROWS]; bit r is row r.
- blink_en  in  1  enables blinking of the displayed page.
- columns  out  COLS  one-hot column drive, active-high.
- lines  out  ROWS  row data for the driven column, active-high.
- col_idx  out  $clog2(COLS)  index of the current column slot.
- frame_start  out  1  one-cycle pulse on the first output cycle of column 0.

## Operation
- States: IDLE, BLANK, DRIVE. All outputs are registered.
- Reset: state IDLE; columns=0, lines=0, col_idx=0, frame_start=0; shadow page, dwell counter and frame counter cleared; blink phase visible.
- IDLE with enable=1 at an edge: enter column 0, in BLANK if BLANK>0, else in DRIVE.
- Entering column 0, from IDLE or by wrap, latches page_sel and the selected page into a shadow register. Columns 1..COLS-1 of that frame use the shadow, so page_sel and frame_data changes mid-frame never tear.
- BLANK: columns=0, lines=0 for exactly BLANK cycles, then DRIVE for the same column.
- DRIVE: columns=1<<col, lines=shadow column data, masked to 0 in the blink-off phase, for exactly DWELL cycles.
- After the last DRIVE cycle, advance to col+1. After column COLS-1, wrap to 0, relatch, and count one completed frame.
- Frame period: COLS*(BLANK+DWELL) cycles, with no gap on wrap.
- Blink: the frame counter wraps at BLINK_FRAMES and toggles the blink phase on each wrap.
  - While blink_en=0, the frame counter and phase are held at 0 and visible.
  - Columns keep scanning in the off phase; only lines is zeroed.
- page_sel ≥ PAGES when latched: that frame shows lines=0.
- enable=0 at any edge: next cycle is IDLE, columns=0, lines=0, col_idx=0, counters cleared. Re-enable restarts at column 0 with a fresh latch and a frame_start pulse.
- col_idx equals the current column during both BLANK and DRIVE.

## Timing
- Latency: enable sampled high at edge N gives the first column-0 output and frame_start=1 on cycle N+1.
- The column-0 lines value comes from frame_data and page_sel sampled at the same edge that latches the shadow.
- frame_start is high for exactly one cycle per frame, on column 0's first cycle (BLANK or DRIVE).
- columns is never non-zero during BLANK, and never has more than one bit set.
- rst_n assertion mid-frame clears all outputs immediately, independent of clk. The first scan starts one edge after rst_n deasserts with enable=1.

## Test plan
- Defaults, page 0 columns set to 7'h3C, 7'h1D, 7'h35, 7'h47, 7'h77; enable high → columns cycles 00001..10000 one per clock, lines match each column, frame_start every 5 cycles.
- DWELL=3, BLANK=1 → each column shows 1 blank cycle (columns=0, lines=0) then 3 driven cycles; frame period 20; frame_start on the blank cycle of column 0.
- Toggle page_sel 0→1 while column 2 is driven → columns 3-4 still show page 0; the next frame shows page 1 from column 0.
- blink_en=1, BLINK_FRAMES=2 → lines zeroed for frames 2-3 and restored for frames 4-5, with columns still scanning. blink_en=0 → lines visible next frame.
- Drop enable mid-column 3 → outputs 0 and col_idx 0 the next cycle. Re-raise → column 0 with frame_start the cycle after.
- Assert rst_n low mid-DRIVE, asynchronously between edges → columns, lines and frame_start read 0 before the next edge. page_sel=3 with PAGES=2 → lines=0 for that whole frame.

Source files
------------

// File: rtl/matrix_scan_ctrl.sv
// +-----------------------------------------------------------------------------+
// | matrix_scan_ctrl                                                            |
// | Column-multiplexed LED matrix scanner: paged shadow frame, dwell, blanking, |
// | blink. Revision: 1.0                                                        |
// +-----------------------------------------------------------------------------+
`default_nettype none

module matrix_scan_ctrl #(
    parameter int COLS         = 5,
    parameter int ROWS         = 7,
    parameter int PAGES        = 2,
    parameter int DWELL        = 1,
    parameter int BLANK        = 0,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [$clog2(PAGES)-1:0]      page_sel,
    input  logic [PAGES*COLS*ROWS-1:0]    frame_data,
    input  logic                          blink_en,
    output logic [COLS-1:0]               columns,
    output logic [ROWS-1:0]               lines,
    output logic [$clog2(COLS)-1:0]       col_idx,
    output logic                          frame_start
);

    localparam int PSW  = $clog2(PAGES);
    localparam int CW   = $clog2(COLS);
    localparam int CR   = COLS * ROWS;
    localparam int MAXC = (BLANK > DWELL) ? BLANK : DWELL;
    localparam int CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL - 1);
    localparam logic [CW-1:0]   COL_LAST   = CW'(COLS - 1);
    localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [PSW:0]    PAGES_C    = (PSW + 1)'(PAGES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [CNTW-1:0]   cnt;
    logic [CR-1:0]     shadow;
    logic              shadow_ok;
    logic [BW-1:0]     bcnt;
    logic              phase;

    state_t            nstate;
    logic [CW-1:0]     ncol;
    logic [CNTW-1:0]   ncnt;
    logic [CR-1:0]     nshadow;
    logic              nok;
    logic [BW-1:0]     nbcnt;
    logic              nphase;
    logic [COLS-1:0]   ncolumns;
    logic [ROWS-1:0]   nlines;
    logic [ROWS-1:0]   col_data;
    logic [CR-1:0]     page_data;
    logic              page_ok;
    logic              last_blank;
    logic              last_drive;
    logic              wrap;
    logic              latch;

    always_comb begin
        last_blank = (state == S_BLANK) && (cnt == BLANK_LAST);
        last_drive = (state == S_DRIVE) && (cnt == DWELL_LAST);
        wrap       = last_drive && (col == COL_LAST);
        latch      = enable && ((state == S_IDLE) || wrap);

        // Out-of-range page selects match no page and blank the whole frame.
        page_data = '0;
        for (int p = 0; p < PAGES; p++) begin
            if (page_sel == PSW'(p)) begin
                page_data = frame_data[p*CR +: CR];
            end
        end
        page_ok = ({1'b0, page_sel} < PAGES_C);

        if (!enable) begin
            nstate = S_IDLE;
            ncol   = '0;
            ncnt   = '0;
        end else if (latch || last_drive) begin
            nstate = (BLANK > 0) ? S_BLANK : S_DRIVE;
            ncol   = latch ? '0 : col + CW'(1);
            ncnt   = '0;
        end else if (last_blank) begin
            nstate = S_DRIVE;
            ncol   = col;
            ncnt   = '0;
        end else begin
            nstate = state;
            ncol   = col;
            ncnt   = cnt + CNTW'(1);
        end

        if (!enable || !blink_en) begin
            nbcnt  = '0;
            nphase = 1'b0;
        end else if (wrap) begin
            nbcnt  = (bcnt == BLINK_LAST) ? '0 : bcnt + BW'(1);
            nphase = (bcnt == BLINK_LAST) ? ~phase : phase;
        end else begin
            nbcnt  = bcnt;
            nphase = phase;
        end

        // Column 0 is driven straight from the page being latched on this edge.
        nshadow = latch ? page_data : shadow;
        nok     = latch ? page_ok : shadow_ok;

        col_data = '0;
        ncolumns = '0;
        for (int c = 0; c < COLS; c++) begin
            if (ncol == CW'(c)) begin
                col_data    = nshadow[c*ROWS +: ROWS];
                ncolumns[c] = (nstate == S_DRIVE);
            end
        end
        nlines = (nstate == S_DRIVE && nok && !nphase) ? col_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            col         <= '0;
            cnt         <= '0;
            shadow      <= '0;
            shadow_ok   <= 1'b0;
            bcnt        <= '0;
            phase       <= 1'b0;
            columns     <= '0;
            lines       <= '0;
            col_idx     <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= nstate;
            col         <= ncol;
            cnt         <= ncnt;
            shadow      <= nshadow;
            shadow_ok   <= nok;
            bcnt        <= nbcnt;
            phase       <= nphase;
            columns     <= ncolumns;
            lines       <= nlines;
            col_idx     <= ncol;
            frame_start <= latch;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_matrix_scan_ctrl                                                         |
// | Scoreboard bench for two scanner configurations sharing one stimulus.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_matrix_scan_ctrl;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [1:0]   psel;
    logic [104:0] fd;
    logic         blink_en;

    logic [4:0] cols_a, cols_b;
    logic [6:0] lines_a, lines_b;
    logic [2:0] idx_a, idx_b;
    logic       fs_a, fs_b;

    matrix_scan_ctrl #(
        .COLS(5), .ROWS(7), .PAGES(3), .DWELL(1), .BLANK(0), .BLINK_FRAMES(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .page_sel(psel),
        .frame_data(fd), .blink_en(blink_en), .columns(cols_a),
        .lines(lines_a), .col_idx(idx_a), .frame_start(fs_a)
    );

    matrix_scan_ctrl #(
        .COLS(5), .ROWS(7), .PAGES(2), .DWELL(3), .BLANK(1), .BLINK_FRAMES(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .page_sel(psel[0]),
        .frame_data(fd[69:0]), .blink_en(blink_en), .columns(cols_b),
        .lines(lines_b), .col_idx(idx_b), .frame_start(fs_b)
    );

    typedef struct packed {
        logic [4:0] cols;
        logic [6:0] lines;
        logic [2:0] idx;
        logic       fs;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_err = 0;

    int           m_run[2];
    int           m_t[2];
    int           m_bcnt[2];
    int           m_phase[2];
    int           m_psel[2];
    logic [104:0] m_fd[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference: position within the frame is a single cycle count t.
    function automatic exp_t predict(input int k, input int nb, input int nd, input int pages);
        exp_t e;
        int   slot;
        int   c;
        e = '0;
        if (m_run[k] != 0) begin
            slot  = m_t[k] % (nb + nd);
            c     = m_t[k] / (nb + nd);
            e.idx = 3'(c);
            e.fs  = (m_t[k] == 0);
            if (slot >= nb) begin
                e.cols = 5'(1) << c;
                if (m_phase[k] == 0 && m_psel[k] < pages)
                    e.lines = 7'(m_fd[k] >> ((m_psel[k] * 5 + c) * 7));
            end
        end
        return e;
    endfunction

    task automatic step(input int k, input int nb, input int nd, input int pages);
        int per;
        int ps;
        per = 5 * (nb + nd);
        ps  = (k == 0) ? int'(psel) : int'(psel[0]);
        if (!rst_n || !enable) begin
            m_run[k] = 0; m_t[k] = 0; m_bcnt[k] = 0; m_phase[k] = 0;
        end else begin
            if (m_run[k] == 0) begin
                m_run[k] = 1; m_t[k] = 0; m_psel[k] = ps; m_fd[k] = fd;
            end else if (m_t[k] == per - 1) begin
                m_t[k] = 0; m_psel[k] = ps; m_fd[k] = fd;
                if (blink_en) begin
                    m_bcnt[k]++;
                    if (m_bcnt[k] == 2) begin
                        m_bcnt[k] = 0;
                        m_phase[k] = 1 - m_phase[k];
                    end
                end
            end else begin
                m_t[k]++;
            end
            if (!blink_en) begin
                m_bcnt[k] = 0; m_phase[k] = 0;
            end
        end
    endtask

    always @(negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_t[k] = 0; m_bcnt[k] = 0; m_phase[k] = 0;
        end
    end

    always @(posedge clk) begin
        step(0, 0, 1, 3);
        step(1, 1, 3, 2);
        q0.push_back(predict(0, 0, 1, 3));
        q1.push_back(predict(1, 1, 3, 2));
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() == 0 || q1.size() == 0) begin
            check("queue_empty", 32'(q0.size() + q1.size()), 32'd2);
        end else begin
            e = q0.pop_front();
            check("A.columns",     32'(cols_a),  32'(e.cols));
            check("A.lines",       32'(lines_a), 32'(e.lines));
            check("A.col_idx",     32'(idx_a),   32'(e.idx));
            check("A.frame_start", 32'(fs_a),    32'(e.fs));
            e = q1.pop_front();
            check("B.columns",     32'(cols_b),  32'(e.cols));
            check("B.lines",       32'(lines_b), 32'(e.lines));
            check("B.col_idx",     32'(idx_b),   32'(e.idx));
            check("B.frame_start", 32'(fs_b),    32'(e.fs));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_t(input int k, input int tgt);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (m_run[k] != 0 && m_t[k] == tgt) found = 1'b1;
        end
        if (!found) check("wait_timeout", 32'(found), 32'd1);
    endtask

    task automatic set_col(input int p, input int c, input logic [6:0] v);
        fd[(p*5 + c)*7 +: 7] = v;
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        blink_en = 1'b0;
        psel     = 2'd0;
        fd       = '0;
        set_col(0, 0, 7'h3C); set_col(0, 1, 7'h1D); set_col(0, 2, 7'h35);
        set_col(0, 3, 7'h47); set_col(0, 4, 7'h77);
        set_col(1, 0, 7'h41); set_col(1, 1, 7'h22); set_col(1, 2, 7'h14);
        set_col(1, 3, 7'h08); set_col(1, 4, 7'h7F);
        set_col(2, 0, 7'h2A); set_col(2, 1, 7'h55); set_col(2, 2, 7'h0F);
        set_col(2, 3, 7'h70); set_col(2, 4, 7'h33);

        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        enable = 1'b1;
        cycles(24);

        // Page switch and data edit mid-frame must not tear the current frame.
        wait_t(0, 2);
        psel = 2'd1;
        set_col(0, 3, 7'h2B);
        cycles(45);

        wait_t(0, 4);
        psel = 2'd0;
        blink_en = 1'b1;
        cycles(40);
        wait_t(0, 4);
        blink_en = 1'b0;
        cycles(12);

        wait_t(0, 4);
        psel = 2'd3;
        cycles(22);
        wait_t(0, 4);
        psel = 2'd0;

        wait_t(0, 3);
        enable = 1'b0;
        cycles(3);
        enable = 1'b1;
        cycles(27);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async.A.columns",     32'(cols_a),  32'd0);
        check("async.A.lines",       32'(lines_a), 32'd0);
        check("async.A.frame_start", 32'(fs_a),    32'd0);
        check("async.B.columns",     32'(cols_b),  32'd0);
        check("async.B.lines",       32'(lines_b), 32'd0);
        check("async.B.frame_start", 32'(fs_b),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(25);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
